// File: rtl/handshake_pkg.sv
// Shared types and constants for the bus word unpacker:
// request FSM states and beat geometry.
package handshake_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } req_state_t;

    localparam int BEATS      = 4;
    localparam int DEF_BYTE_W = 8;
    localparam int BEAT_W     = 2 * DEF_BYTE_W;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with one write and one read port.
// A simultaneous write and read keeps the count unchanged.
module word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];
    // A pop on the same edge frees the slot, so a write into a full FIFO is legal then.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_word_unpacker.sv
// Requests a word from the shared bus, buffers it and serialises it
// as four byte-pair beats towards the display path.
module bus_word_unpacker
    import handshake_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clkB,
    input  logic              reset,
    input  logic              start,
    output logic              reqA,
    input  logic              gntA,
    input  logic [WORD_W-1:0] sharedBus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] printd0,
    output logic [BYTE_W-1:0] printd1,
    output logic              full,
    output logic              busy,
    output req_state_t        state
);

    localparam int PAIR_W = 2 * BYTE_W;

    req_state_t        state_d;
    logic              capture;
    logic              empty;
    logic [WORD_W-1:0] head;
    logic [1:0]        k;
    logic              fire;
    logic              pop;
    logic [PAIR_W-1:0] beat;

    // Request FSM: one bus transaction per accepted start.
    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE: if (start && !full) state_d = REQ;
            REQ: begin
                if (gntA) begin
                    capture = 1'b1;
                    state_d = REL;
                end
            end
            REL:  if (!gntA) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkB or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            reqA  <= 1'b0;
        end else begin
            state <= state_d;
            reqA  <= (state_d == REQ);
        end
    end

    assign busy = (state != IDLE);

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clkB),
        .rst_n   (reset),
        .wr_en   (capture),
        .wr_data (sharedBus),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (empty),
        .full    (full)
    );

    // Handshake: a beat transfers on any edge where out_valid && out_ready;
    // while out_valid is high and out_ready low the beat is held unchanged.
    assign out_valid = !empty;
    assign fire      = out_valid && out_ready;
    assign pop       = fire && (k == 2'(BEATS - 1));

    always_ff @(posedge clkB or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (fire) begin
            k <= pop ? '0 : k + 2'd1;
        end
    end

    always_comb begin
        beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (k == 2'(b)) beat = head[b*PAIR_W +: PAIR_W];
        end
    end

    assign printd0 = empty ? '0 : beat[BYTE_W-1:0];
    assign printd1 = empty ? '0 : beat[PAIR_W-1:BYTE_W];

endmodule
